reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter, giving a max count of 2^CNT_W-1.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wr_we  in  1  write enable from the writeback stage.
REQ-005 wr_idx  in  5  destination register index from the writeback stage.
REQ-006 wr_data  in  32  write data from the writeback stage.
REQ-007 rd0_idx, rd1_idx  in  5 each  read-port register indices from the decode/issue stage.
REQ-008 rd0_data, rd1_data  out  32 each  read-port data.
REQ-009 rd0_busy, rd1_busy  out  1 each  the indexed register has an outstanding write.
REQ-010 sb_set  in  1  issue marks a new in-flight write to sb_idx.
REQ-011 sb_idx  in  5  destination index for sb_set.
REQ-012 sb_ready  out  1  sb_set would be accepted this cycle.
REQ-013 flush_i  in  1  pipeline flush; discards all scoreboard state.
REQ-014 err_o  out  1  sticky protocol-error flag.

Function
REQ-015 Storage SHALL be 32 x 32-bit registers; register 0 SHALL read 0 and ignore writes.
REQ-016 A write SHALL update regs[wr_idx] at the posedge where wr_we=1 and wr_idx!=0.
REQ-017 Reads SHALL be combinational; when wr_we=1, wr_idx==rdN_idx and rdN_idx!=0, rdN_data SHALL equal wr_data in the same cycle (write-through bypass).
REQ-018 Each register i!=0 SHALL have a CNT_W-bit counter cnt[i]; cnt[0] SHALL be constant 0.
REQ-019 The increment condition inc[i] SHALL be sb_set & sb_ready & sb_idx==i & i!=0 & ~flush_i.
REQ-020 The decrement condition dec[i] SHALL be wr_we & wr_idx==i & i!=0 & cnt[i]!=0.
REQ-021 Per cycle: inc only -> cnt+1; dec only -> cnt-1; both -> unchanged; neither -> unchanged.
REQ-022 sb_ready SHALL be 1 iff sb_idx==0, or cnt[sb_idx] < max, or (cnt[sb_idx]==max and the same index is decremented this cycle).
REQ-023 When sb_set=1 and sb_ready=0, the set SHALL be dropped, the counter SHALL hold, and err_o SHALL be set.
REQ-024 wr_we=1 with wr_idx!=0 and cnt[wr_idx]==0 SHALL still write regs, SHALL leave the counter at 0, and SHALL set err_o, unless flush_i was asserted in the previous cycle.
REQ-025 rdN_busy SHALL be 0 for idx 0, and otherwise equal (cnt[idx] - dec[idx]) != 0, i.e. a write retiring this cycle clears busy combinationally in the same cycle.
REQ-026 flush_i=1 SHALL zero all counters at the next posedge; inc requests in that cycle SHALL be ignored; a regfile write in that cycle SHALL still be performed.
REQ-027 err_o, once set, SHALL remain 1 until rst.
REQ-028 All outputs except the registered err_o SHALL be combinational from state and inputs; there SHALL be no added latency.

Reset
REQ-029 While rst=1 at a posedge: all regs SHALL be cleared to 0, all cnt cleared to 0, and err_o cleared to 0; wr_we and sb_set SHALL be ignored.
REQ-030 After reset, the outputs SHALL be rd0_busy=rd1_busy=0, sb_ready=1, err_o=0, and rd*_data=0 for any index.
REQ-031 Reset asserted mid-operation (counters nonzero) SHALL yield the REQ-030 state on the next cycle.

Verification
REQ-032 Write/read: wr_we=1, wr_idx=5, wr_data=0xDEADBEEF; in the same cycle rd0_idx=5 -> rd0_data=0xDEADBEEF (bypass); the next cycle with wr_we=0 -> rd0_data=0xDEADBEEF.
REQ-033 r0: wr_we=1, wr_idx=0, data=0x1234; sb_set on idx 0 -> rd0_data=0, rd0_busy=0, counters unchanged, err_o=0.
REQ-034 Saturation: three sb_set on idx 7 (CNT_W=2) -> cnt=3 and sb_ready=0; a 4th sb_set alone -> dropped, err_o=1; sb_set and wr_we on idx 7 together -> accepted, cnt remains 3.
REQ-035 Retire-clears-busy: cnt[9]=1, wr_we on idx 9 and rd1_idx=9 -> rd1_busy=0 and rd1_data=wr_data in the same cycle; next cycle cnt[9]=0.
REQ-036 Flush: cnt[3]=2, cnt[4]=1, flush_i=1 with sb_set idx 3 and wr_we idx 4 data 0x55 -> all counters 0 next cycle, regs[4]=0x55, err_o=0; then wr_we idx 3 -> regs written, err_o=0 only if the flush was in the previous cycle.
REQ-037 Reset mid-run: nonzero counters and err_o=1, rst=1 for one cycle -> all busy=0, sb_ready=1, err_o=0, rd*_data=0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
// 32 x 32-bit register file with a per-register pending-write scoreboard.
// Issue marks in-flight writes (sb_set), writeback retires them (wr_we).
// Reads are combinational, with write-through bypass from the writeback port.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   wr_we/wr_idx/wr_data: writeback write port (also retires a pending write)
//   rd0_idx, rd1_idx    : read indices; rd*_data / rd*_busy are combinational
//   sb_set, sb_idx      : issue request to mark sb_idx as pending
//   sb_ready            : sb_set would be accepted this cycle
//   flush_i             : clears every pending counter at the next edge
//   err_o               : sticky protocol error (overflowing set, or a write
//                         with nothing pending outside the post-flush cycle)
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_we,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd0_idx,
    input  logic [4:0]  rd1_idx,
    output logic [31:0] rd0_data,
    output logic [31:0] rd1_data,
    output logic        rd0_busy,
    output logic        rd1_busy,
    input  logic        sb_set,
    input  logic [4:0]  sb_idx,
    output logic        sb_ready,
    input  logic        flush_i,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      r_regs [32];
    logic [CNT_W-1:0] r_cnt  [32];
    logic             r_err;
    logic             r_flush_d;

    logic [31:0]      w_inc;
    logic [31:0]      w_dec;
    logic             w_sb_ready;
    logic             w_err_set;

    // A saturated counter can still accept a set when the same index retires
    // in this cycle: the increment and decrement cancel out.
    assign w_sb_ready = (sb_idx == 5'd0) ||
                        (r_cnt[sb_idx] != CNT_MAX) ||
                        (wr_we && (wr_idx == sb_idx));

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < 32; i++) begin
            w_inc[i] = sb_set && w_sb_ready && (sb_idx == 5'(i)) && !flush_i;
            w_dec[i] = wr_we && (wr_idx == 5'(i)) && (r_cnt[i] != '0);
        end
    end

    // Writes arriving right after a flush belong to instructions whose pending
    // marks the flush wiped, so they are not treated as unexpected.
    assign w_err_set = (sb_set && !w_sb_ready) ||
                       (wr_we && (wr_idx != 5'd0) && (r_cnt[wr_idx] == '0) && !r_flush_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_err     <= 1'b0;
            r_flush_d <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_we && (wr_idx == 5'(i))) begin
                    r_regs[i] <= wr_data;
                end
            end
            for (int i = 0; i < 32; i++) begin
                if (flush_i) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_flush_d <= flush_i;
        end
    end

    always_comb begin
        rd0_data = r_regs[rd0_idx];
        if (rd0_idx == 5'd0) begin
            rd0_data = '0;
        end else if (wr_we && (wr_idx == rd0_idx)) begin
            rd0_data = wr_data;
        end
        rd1_data = r_regs[rd1_idx];
        if (rd1_idx == 5'd0) begin
            rd1_data = '0;
        end else if (wr_we && (wr_idx == rd1_idx)) begin
            rd1_data = wr_data;
        end
    end

    // Busy reflects the count after any retirement happening this cycle.
    assign rd0_busy = (rd0_idx != 5'd0) &&
                      ((r_cnt[rd0_idx] - CNT_W'(w_dec[rd0_idx])) != '0);
    assign rd1_busy = (rd1_idx != 5'd0) &&
                      ((r_cnt[rd1_idx] - CNT_W'(w_dec[rd1_idx])) != '0);

    assign sb_ready = w_sb_ready;
    assign err_o    = r_err;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_we;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [4:0]  rd0_idx;
    logic [4:0]  rd1_idx;
    logic [31:0] rd0_data;
    logic [31:0] rd1_data;
    logic        rd0_busy;
    logic        rd1_busy;
    logic        sb_set;
    logic [4:0]  sb_idx;
    logic        sb_ready;
    logic        flush_i;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    reg_file_scoreboard #(.CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_we    (wr_we),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd0_idx  (rd0_idx),
        .rd1_idx  (rd1_idx),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data),
        .rd0_busy (rd0_busy),
        .rd1_busy (rd1_busy),
        .sb_set   (sb_set),
        .sb_idx   (sb_idx),
        .sb_ready (sb_ready),
        .flush_i  (flush_i),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_we = 1'b0; wr_idx = '0; wr_data = '0;
        sb_set = 1'b0; sb_idx = '0; flush_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd0_idx = '0; rd1_idx = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        rd0_idx = 5'd5; rd1_idx = 5'd31;
        #1;
        chk("rst_busy0", 32'(rd0_busy), 32'd0);
        chk("rst_busy1", 32'(rd1_busy), 32'd0);
        chk("rst_ready", 32'(sb_ready), 32'd1);
        chk("rst_err",   32'(err_o),    32'd0);
        chk("rst_data0", rd0_data, 32'd0);
        chk("rst_data1", rd1_data, 32'd0);

        // write/read on r5, with a matching pending mark first
        sb_set = 1'b1; sb_idx = 5'd5;
        #1;
        chk("wr_set_ready", 32'(sb_ready), 32'd1);
        tick();
        idle();
        #1;
        chk("wr_busy_pending", 32'(rd0_busy), 32'd1);
        wr_we = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        chk("wr_bypass", rd0_data, 32'hDEADBEEF);
        chk("wr_retire_busy", 32'(rd0_busy), 32'd0);
        tick();
        idle();
        #1;
        chk("wr_stored", rd0_data, 32'hDEADBEEF);
        chk("wr_err", 32'(err_o), 32'd0);

        // register 0 is hardwired
        wr_we = 1'b1; wr_idx = 5'd0; wr_data = 32'h1234;
        sb_set = 1'b1; sb_idx = 5'd0; rd0_idx = 5'd0;
        #1;
        chk("r0_bypass", rd0_data, 32'd0);
        chk("r0_ready", 32'(sb_ready), 32'd1);
        tick();
        idle();
        #1;
        chk("r0_data", rd0_data, 32'd0);
        chk("r0_busy", 32'(rd0_busy), 32'd0);
        chk("r0_err", 32'(err_o), 32'd0);

        // retire clears busy in the same cycle (r9)
        sb_set = 1'b1; sb_idx = 5'd9; rd1_idx = 5'd9;
        tick();
        idle();
        #1;
        chk("ret_busy_before", 32'(rd1_busy), 32'd1);
        wr_we = 1'b1; wr_idx = 5'd9; wr_data = 32'hA5A50009;
        #1;
        chk("ret_busy_same", 32'(rd1_busy), 32'd0);
        chk("ret_bypass", rd1_data, 32'hA5A50009);
        tick();
        idle();
        #1;
        chk("ret_busy_after", 32'(rd1_busy), 32'd0);
        chk("ret_data", rd1_data, 32'hA5A50009);

        // flush: cnt[3]=2, cnt[4]=1
        sb_set = 1'b1; sb_idx = 5'd3; tick();
        sb_idx = 5'd3; tick();
        sb_idx = 5'd4; tick();
        idle();
        rd0_idx = 5'd3; rd1_idx = 5'd4;
        #1;
        chk("fl_busy3_pre", 32'(rd0_busy), 32'd1);
        chk("fl_busy4_pre", 32'(rd1_busy), 32'd1);
        flush_i = 1'b1; sb_set = 1'b1; sb_idx = 5'd3;
        wr_we = 1'b1; wr_idx = 5'd4; wr_data = 32'h55;
        tick();
        idle();
        #1;
        chk("fl_busy3", 32'(rd0_busy), 32'd0);
        chk("fl_busy4", 32'(rd1_busy), 32'd0);
        chk("fl_data4", rd1_data, 32'h55);
        chk("fl_err", 32'(err_o), 32'd0);
        // write right after the flush is excused
        wr_we = 1'b1; wr_idx = 5'd3; wr_data = 32'h33;
        tick();
        idle();
        #1;
        chk("fl_post_data", rd0_data, 32'h33);
        chk("fl_post_err", 32'(err_o), 32'd0);
        // same write one cycle later is an error
        wr_we = 1'b1; wr_idx = 5'd3; wr_data = 32'h66;
        tick();
        idle();
        #1;
        chk("unexp_wr_data", rd0_data, 32'h66);
        chk("unexp_wr_err", 32'(err_o), 32'd1);
        tick();
        #1;
        chk("err_sticky", 32'(err_o), 32'd1);

        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        chk("rst2_err", 32'(err_o), 32'd0);

        // saturation on r7
        rd1_idx = 5'd7;
        sb_set = 1'b1; sb_idx = 5'd7;
        tick(); tick(); tick();
        #1;
        chk("sat_ready", 32'(sb_ready), 32'd0);
        chk("sat_busy", 32'(rd1_busy), 32'd1);
        chk("sat_err_pre", 32'(err_o), 32'd0);
        tick();
        #1;
        chk("sat_drop_err", 32'(err_o), 32'd1);
        wr_we = 1'b1; wr_idx = 5'd7; wr_data = 32'h77;
        #1;
        chk("sat_both_ready", 32'(sb_ready), 32'd1);
        chk("sat_both_busy", 32'(rd1_busy), 32'd1);
        chk("sat_both_bypass", rd1_data, 32'h77);
        tick();
        idle();
        sb_idx = 5'd7;
        #1;
        chk("sat_hold_ready", 32'(sb_ready), 32'd0);
        sb_idx = 5'd0;
        #1;
        chk("sat_idx0_ready", 32'(sb_ready), 32'd1);

        // reset mid-run with cnt[7]=3 and err_o=1
        rst = 1'b1; tick(); rst = 1'b0;
        rd0_idx = 5'd5; rd1_idx = 5'd7; sb_idx = 5'd7;
        #1;
        chk("mid_busy0", 32'(rd0_busy), 32'd0);
        chk("mid_busy1", 32'(rd1_busy), 32'd0);
        chk("mid_ready", 32'(sb_ready), 32'd1);
        chk("mid_err", 32'(err_o), 32'd0);
        chk("mid_data0", rd0_data, 32'd0);
        chk("mid_data1", rd1_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
